// File: rtl/rotor_setup_ctrl.sv
// Debounced four-button editor that dials rotor start positions and commits them
// as single-cycle writes on the rotor configuration bus.
module rotor_setup_ctrl #(
    parameter int DEBOUNCE_CYCLES = 100000,
    parameter int NUM_POS         = 26
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_sel,
    input  logic       btn_ok,
    output logic [1:0] rotor_pos_out,
    output logic [4:0] init_pos_out,
    output logic       write_en,
    output logic [1:0] rotor_sel,
    output logic [4:0] edit_val,
    output logic       config_done
);

    localparam int            CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [4:0]    POS_MAX  = 5'(NUM_POS - 1);

    typedef enum logic [2:0] {
        ACT_NONE,
        ACT_OK,
        ACT_SEL,
        ACT_UP,
        ACT_DOWN
    } action_t;

    // Button vector order: {ok, sel, up, down}
    logic [3:0]    w_btn_raw;
    logic [3:0]    r_sync1;
    logic [3:0]    r_sync2;
    logic [3:0]    r_deb;
    logic [3:0]    r_deb_d;
    logic [CW-1:0] r_cnt [4];
    logic [3:0]    w_press;
    action_t       w_act;

    logic [1:0]    r_rotor_sel;
    logic [4:0]    r_edit_val;
    logic [4:0]    r_shadow [3];
    logic [2:0]    r_done_mask;
    logic [1:0]    r_rotor_pos;
    logic [4:0]    r_init_pos;
    logic          r_write_en;
    logic          r_config_done;
    logic [1:0]    w_next_sel;

    assign w_btn_raw = {btn_ok, btn_sel, btn_up, btn_down};

    // NOTE: all state is updated with <= so every register sees pre-edge values
    // of its neighbours, regardless of statement order inside the block.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_deb   <= '0;
            r_deb_d <= '0;
            for (int i = 0; i < 4; i++) r_cnt[i] <= '0;
        end else begin
            r_sync1 <= w_btn_raw;
            r_sync2 <= r_sync1;
            r_deb_d <= r_deb;
            for (int i = 0; i < 4; i++) begin
                if (r_sync2[i] == r_deb[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == CNT_LAST) begin
                    r_deb[i] <= r_sync2[i];
                    r_cnt[i] <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + CW'(1);
                end
            end
        end
    end

    assign w_press    = r_deb & ~r_deb_d;
    assign w_next_sel = (r_rotor_sel == 2'd2) ? 2'd0 : r_rotor_sel + 2'd1;

    // NOTE: w_act is given a default before the priority chain so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        w_act = ACT_NONE;
        if (w_press[3])      w_act = ACT_OK;
        else if (w_press[2]) w_act = ACT_SEL;
        else if (w_press[1]) w_act = ACT_UP;
        else if (w_press[0]) w_act = ACT_DOWN;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rotor_sel   <= 2'd0;
            r_edit_val    <= 5'd0;
            r_done_mask   <= 3'b000;
            r_rotor_pos   <= 2'b11;
            r_init_pos    <= 5'd0;
            r_write_en    <= 1'b0;
            r_config_done <= 1'b0;
            // NOTE: shadows are reset because a rotor reloaded before its first
            // commit must present position 0, not power-up garbage.
            for (int i = 0; i < 3; i++) r_shadow[i] <= 5'd0;
        end else begin
            r_write_en    <= 1'b0;
            r_rotor_pos   <= 2'b11;
            r_init_pos    <= r_edit_val;
            r_config_done <= r_config_done | (&r_done_mask);
            case (w_act)
                ACT_OK: begin
                    r_write_en                <= 1'b1;
                    r_rotor_pos               <= r_rotor_sel;
                    r_shadow[r_rotor_sel]     <= r_edit_val;
                    r_done_mask[r_rotor_sel]  <= 1'b1;
                    r_rotor_sel               <= w_next_sel;
                    r_edit_val                <= r_shadow[w_next_sel];
                end
                ACT_SEL: begin
                    r_rotor_sel <= w_next_sel;
                    r_edit_val  <= r_shadow[w_next_sel];
                end
                ACT_UP:   r_edit_val <= (r_edit_val == POS_MAX) ? 5'd0 : r_edit_val + 5'd1;
                ACT_DOWN: r_edit_val <= (r_edit_val == 5'd0) ? POS_MAX : r_edit_val - 5'd1;
                default: ;
            endcase
        end
    end

    assign rotor_pos_out = r_rotor_pos;
    assign init_pos_out  = r_init_pos;
    assign write_en      = r_write_en;
    assign rotor_sel     = r_rotor_sel;
    assign edit_val      = r_edit_val;
    assign config_done   = r_config_done;

endmodule

// File: tb/tb_rotor_setup_ctrl.sv
// Randomized bench for rotor_setup_ctrl: a position/rotor model driven by button
// presses predicts the edit state and every write strobe.
module tb_rotor_setup_ctrl;

    localparam int D  = 4;
    localparam int NP = 26;

    logic       clk = 1'b0;
    logic       rst;
    logic       btn_up, btn_down, btn_sel, btn_ok;
    logic [1:0] rotor_pos_out;
    logic [4:0] init_pos_out;
    logic       write_en;
    logic [1:0] rotor_sel;
    logic [4:0] edit_val;
    logic       config_done;

    int vectors     = 0;
    int miscompares = 0;
    int idle_bad    = 0;

    // Reference model: rotor index, dial value, saved values, commit set
    int         m_sel, m_val;
    int         m_shadow [3];
    logic [2:0] m_mask;
    logic       m_done;

    logic [6:0] obs_q [$];

    rotor_setup_ctrl #(.DEBOUNCE_CYCLES(D), .NUM_POS(NP)) dut (
        .clk(clk), .rst(rst),
        .btn_up(btn_up), .btn_down(btn_down), .btn_sel(btn_sel), .btn_ok(btn_ok),
        .rotor_pos_out(rotor_pos_out), .init_pos_out(init_pos_out),
        .write_en(write_en), .rotor_sel(rotor_sel), .edit_val(edit_val),
        .config_done(config_done)
    );

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1);
    end

    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (write_en === 1'b1) obs_q.push_back({rotor_pos_out, init_pos_out});
            else if (rotor_pos_out !== 2'b11) idle_bad++;
        end
    end

    function automatic void model_reset();
        m_sel = 0; m_val = 0; m_mask = 3'b000; m_done = 1'b0;
        for (int i = 0; i < 3; i++) m_shadow[i] = 0;
    endfunction

    // m = {ok, sel, up, down}; highest-priority button wins
    function automatic void model_apply(input logic [3:0] m, output bit st, output logic [6:0] e);
        st = 1'b0;
        e  = '0;
        if (m[3]) begin
            st = 1'b1;
            e  = {2'(m_sel), 5'(m_val)};
            m_shadow[m_sel] = m_val;
            m_mask[m_sel]   = 1'b1;
            m_sel = (m_sel + 1) % 3;
            m_val = m_shadow[m_sel];
            if (m_mask == 3'b111) m_done = 1'b1;
        end else if (m[2]) begin
            m_sel = (m_sel + 1) % 3;
            m_val = m_shadow[m_sel];
        end else if (m[1]) begin
            m_val = (m_val + 1) % NP;
        end else if (m[0]) begin
            m_val = (m_val + NP - 1) % NP;
        end
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        {btn_ok, btn_sel, btn_up, btn_down} = 4'b0000;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        obs_q.delete();
    endtask

    task automatic press(input logic [3:0] m, input string tag);
        bit         st;
        logic [6:0] e;
        obs_q.delete();
        @(negedge clk);
        {btn_ok, btn_sel, btn_up, btn_down} = m;
        repeat (D + 8) @(negedge clk);
        {btn_ok, btn_sel, btn_up, btn_down} = 4'b0000;
        repeat (D + 8) @(negedge clk);
        model_apply(m, st, e);
        vectors++;
        if (obs_q.size() != int'(st)) begin
            miscompares++;
            $display("FAIL %s strobe_count: got %0d want %0d", tag, obs_q.size(), st);
        end
        if (st && obs_q.size() == 1) begin
            vectors++;
            if (obs_q[0] !== e) begin
                miscompares++;
                $display("FAIL %s strobe: got rotor %0d data %0d want rotor %0d data %0d",
                         tag, obs_q[0][6:5], obs_q[0][4:0], e[6:5], e[4:0]);
            end
        end
        vectors++;
        if (rotor_sel !== 2'(m_sel)) begin
            miscompares++;
            $display("FAIL %s rotor_sel: got %0d want %0d", tag, rotor_sel, m_sel);
        end
        vectors++;
        if (edit_val !== 5'(m_val)) begin
            miscompares++;
            $display("FAIL %s edit_val: got %0d want %0d", tag, edit_val, m_val);
        end
        vectors++;
        if (init_pos_out !== 5'(m_val)) begin
            miscompares++;
            $display("FAIL %s init_pos_out: got %0d want %0d", tag, init_pos_out, m_val);
        end
        vectors++;
        if (config_done !== m_done) begin
            miscompares++;
            $display("FAIL %s config_done: got %b want %b", tag, config_done, m_done);
        end
        vectors++;
        if (write_en !== 1'b0 || rotor_pos_out !== 2'b11) begin
            miscompares++;
            $display("FAIL %s idle_bus: got we %b pos %b want we 0 pos 11", tag, write_en, rotor_pos_out);
        end
    endtask

    task automatic test_reset();
        {btn_ok, btn_sel, btn_up, btn_down} = 4'b0000;
        rst = 1'b0;
        #1 rst = 1'b1;
        #1;
        vectors++;
        if ({rotor_pos_out, init_pos_out, write_en, rotor_sel, edit_val, config_done} !==
            {2'b11, 5'd0, 1'b0, 2'd0, 5'd0, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_values: got pos %b init %0d we %b sel %0d val %0d done %b want pos 11, rest 0",
                     rotor_pos_out, init_pos_out, write_en, rotor_sel, edit_val, config_done);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        press(4'b1000, "reset_ok0");
        press(4'b1000, "reset_ok1");
        press(4'b1000, "reset_ok2");
    endtask

    task automatic test_bounce();
        bit         st;
        logic [6:0] e;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            btn_up = 1'b1;
            repeat (2) @(negedge clk);
            btn_up = 1'b0;
            repeat (2) @(negedge clk);
        end
        btn_up = 1'b1;
        repeat (D + 2) @(posedge clk);
        #1;
        vectors++;
        if (edit_val !== 5'd0) begin
            miscompares++;
            $display("FAIL bounce_early: got %0d want 0", edit_val);
        end
        @(posedge clk);
        #1;
        vectors++;
        if (edit_val !== 5'd1) begin
            miscompares++;
            $display("FAIL bounce_latency: got %0d want 1", edit_val);
        end
        repeat (20) @(negedge clk);
        vectors++;
        if (edit_val !== 5'd1) begin
            miscompares++;
            $display("FAIL bounce_no_repeat: got %0d want 1", edit_val);
        end
        btn_up = 1'b0;
        repeat (D + 8) @(negedge clk);
        model_apply(4'b0010, st, e);
        press(4'b0000, "bounce_settle");
    endtask

    task automatic test_wrap();
        do_reset();
        press(4'b0001, "wrap_down");
        vectors++;
        if (edit_val !== 5'(NP - 1)) begin
            miscompares++;
            $display("FAIL wrap_down_const: got %0d want %0d", edit_val, NP - 1);
        end
        press(4'b0010, "wrap_up");
        for (int i = 0; i < 27; i++) press(4'b0010, "wrap_27");
        vectors++;
        if (edit_val !== 5'd1) begin
            miscompares++;
            $display("FAIL wrap_27_const: got %0d want 1", edit_val);
        end
    endtask

    task automatic test_shadow();
        do_reset();
        for (int i = 0; i < 5; i++) press(4'b0010, "shadow_up5");
        press(4'b1000, "shadow_ok");
        press(4'b0100, "shadow_sel_a");
        press(4'b0100, "shadow_sel_b");
        vectors++;
        if (edit_val !== 5'd5 || rotor_sel !== 2'd0) begin
            miscompares++;
            $display("FAIL shadow_reload: got sel %0d val %0d want sel 0 val 5", rotor_sel, edit_val);
        end
        for (int i = 0; i < 3; i++) press(4'b0010, "shadow_up3");
        press(4'b0100, "shadow_discard");
        press(4'b0100, "shadow_sel_c");
        press(4'b0100, "shadow_sel_d");
        vectors++;
        if (edit_val !== 5'd5) begin
            miscompares++;
            $display("FAIL shadow_kept: got %0d want 5", edit_val);
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        press(4'b0010, "simul_up_a");
        press(4'b0010, "simul_up_b");
        press(4'b1010, "simul_ok_up");
        press(4'b0101, "simul_sel_down");
        vectors++;
        if (rotor_sel !== 2'd2 || edit_val !== 5'd0) begin
            miscompares++;
            $display("FAIL simul_const: got sel %0d val %0d want sel 2 val 0", rotor_sel, edit_val);
        end
    endtask

    task automatic test_held_through_reset();
        bit         st;
        logic [6:0] e;
        @(negedge clk);
        rst = 1'b1;
        btn_up = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        model_reset();
        repeat (D + 2) @(posedge clk);
        #1;
        vectors++;
        if (edit_val !== 5'd0) begin
            miscompares++;
            $display("FAIL held_early: got %0d want 0", edit_val);
        end
        @(posedge clk);
        #1;
        vectors++;
        if (edit_val !== 5'd1) begin
            miscompares++;
            $display("FAIL held_press: got %0d want 1", edit_val);
        end
        @(negedge clk);
        btn_up = 1'b0;
        repeat (D + 8) @(negedge clk);
        model_apply(4'b0010, st, e);
        obs_q.delete();
        press(4'b0000, "held_settle");
    endtask

    task automatic test_reset_mid_strobe();
        int         n;
        bit         st;
        logic [6:0] e;
        do_reset();
        press(4'b0100, "mid_sel");
        press(4'b1000, "mid_ok1");
        press(4'b1000, "mid_ok2");
        @(negedge clk);
        btn_ok = 1'b1;
        n = 0;
        while (write_en !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (write_en !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_wait_strobe: got we %b want 1 within 40 cycles", write_en);
        end
        #1 rst = 1'b1;
        #1;
        vectors++;
        if (write_en !== 1'b0 || rotor_pos_out !== 2'b11 || rotor_sel !== 2'd0 || edit_val !== 5'd0) begin
            miscompares++;
            $display("FAIL mid_async_reset: got we %b pos %b sel %0d val %0d want we 0 pos 11 sel 0 val 0",
                     write_en, rotor_pos_out, rotor_sel, edit_val);
        end
        btn_ok = 1'b0;
        repeat (3) @(negedge clk);
        obs_q.delete();
        rst = 1'b0;
        model_reset();
        repeat (D + 8) @(negedge clk);
        vectors++;
        if (obs_q.size() != 0) begin
            miscompares++;
            $display("FAIL mid_no_partial: got %0d strobes want 0", obs_q.size());
        end
        press(4'b1000, "mid_fresh1");
        press(4'b1000, "mid_fresh2");
        obs_q.delete();
        @(negedge clk);
        btn_ok = 1'b1;
        n = 0;
        while (write_en !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (write_en !== 1'b1 || config_done !== 1'b0) begin
            miscompares++;
            $display("FAIL done_during_strobe: got we %b done %b want we 1 done 0", write_en, config_done);
        end
        @(negedge clk);
        vectors++;
        if (write_en !== 1'b0 || config_done !== 1'b1) begin
            miscompares++;
            $display("FAIL done_after_strobe: got we %b done %b want we 0 done 1", write_en, config_done);
        end
        btn_ok = 1'b0;
        repeat (D + 8) @(negedge clk);
        model_apply(4'b1000, st, e);
        vectors++;
        if (obs_q.size() != 1 || obs_q[0] !== e) begin
            miscompares++;
            $display("FAIL done_strobe_data: got %0d strobes first %h want 1 strobe %h",
                     obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : 7'h0, e);
        end
        press(4'b0010, "after_done_edit");
    endtask

    task automatic test_random();
        logic [3:0] m;
        do_reset();
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 1) == 1) m = 4'b0001 << $urandom_range(0, 3);
            else m = 4'($urandom_range(1, 15));
            press(m, "random");
        end
    endtask

    initial begin
        test_reset();
        test_bounce();
        test_wrap();
        test_shadow();
        test_simultaneous();
        test_held_through_reset();
        test_reset_mid_strobe();
        test_random();
        vectors++;
        if (idle_bad != 0) begin
            miscompares++;
            $display("FAIL idle_rotor_code: got %0d idle cycles with rotor_pos_out != 11 want 0", idle_bad);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/rotor_setup_ctrl.md
# rotor_setup_ctrl

Button-driven configuration writer for the rotor bank. It debounces four raw push-buttons, lets the operator select a rotor and dial its initial position (0..25), and commits each value as a one-cycle write on the `rotor_pos_out`/`init_pos_out` bus. The per-rotor configuration latches decode that bus by rotor code. It sits between the board buttons and the rotor configuration latches; its edit outputs also feed the 7-segment scan logic.

## Interface
- `DEBOUNCE_CYCLES`, default 100000: consecutive stable cycles required before a button level is accepted (1 ms at 100 MHz).
- `NUM_POS`, default 26: number of rotor positions; values wrap in 0..NUM_POS-1.
- `clk`  in  1  system clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `btn_up`  in  1  raw, asynchronous button; increments the edit value.
- `btn_down`  in  1  raw, asynchronous button; decrements the edit value.
- `btn_sel`  in  1  raw, asynchronous button; selects the next rotor.
- `btn_ok`  in  1  raw, asynchronous button; commits the edit value.
- `rotor_pos_out`  out  2  write target: 00/01/10 during a write, 11 (no rotor) otherwise.
- `init_pos_out`  out  5  position data; equals `edit_val`, registered.
- `write_en`  out  1  one-cycle write strobe.
- `rotor_sel`  out  2  rotor currently being edited (0..2).
- `edit_val`  out  5  value currently being edited (0..NUM_POS-1).
- `config_done`  out  1  set once all three rotors have been committed; sticky.

## Operation
- **Input path, per button:**
  - 2-FF synchronizer, then a stability counter.
  - The debounced level takes the synchronized value once that value has differed from the debounced level for DEBOUNCE_CYCLES consecutive cycles.
  - Any bounce resets the counter to 0.
  - A rising edge of the debounced level generates a one-cycle press pulse. Falling edges and held buttons generate nothing (no auto-repeat).
- **Priority:** when several press pulses occur in the same cycle, only one is acted on, in the order ok > sel > up > down. The others are discarded.
- **State:**
  - `rotor_sel`, `edit_val`.
  - Shadow registers `shadow[0..2]` (5 bits each).
  - Commit mask `done_mask[2:0]`.
- **up:** `edit_val` = (`edit_val` == NUM_POS-1) ? 0 : `edit_val`+1.
- **down:** `edit_val` = (`edit_val` == 0) ? NUM_POS-1 : `edit_val`-1.
- **sel:** `rotor_sel` = (`rotor_sel` == 2) ? 0 : `rotor_sel`+1, and `edit_val` is loaded from `shadow[new rotor_sel]`. Edits not yet committed are lost.
- **ok, committing rotor r:**
  - Write cycle: `write_en`=1, `rotor_pos_out`=r, `init_pos_out`=`edit_val`.
  - `shadow[r]` ← `edit_val`, `done_mask[r]` ← 1.
  - `rotor_sel` then advances as for sel, and `edit_val` loads the shadow of the next rotor.
- **Done flag:** `config_done` ← 1 when `done_mask` == 3'b111. It is cleared only by `rst`. Edits and re-commits remain allowed after done.
- **Outside a write cycle:** `rotor_pos_out` = 2'b11 and `write_en` = 0, so no latch captures the value.
- **Reset values:**
  - `rotor_sel`=0, `edit_val`=0, `init_pos_out`=0.
  - `rotor_pos_out`=2'b11, `write_en`=0, `config_done`=0.
  - All shadows=0, `done_mask`=0.
  - Synchronizers, debounced levels and counters=0.

## Timing
- **Button latency:** raw input stable high from the edge at cycle 0 → press pulse is internal and combinationally acted on at cycle DEBOUNCE_CYCLES+2. The updated `edit_val`/`rotor_sel` are visible after edge DEBOUNCE_CYCLES+3.
- **Commit:** ok pulse at cycle N → `write_en`=1 with `rotor_pos_out`/`init_pos_out` valid for exactly cycle N+1. In cycle N+1, `rotor_sel`/`edit_val` already show the next rotor.
  - `init_pos_out` holds the committed value during the strobe. It follows `edit_val` one cycle late otherwise.
- **Done flag:** `config_done` rises in the cycle after the write strobe that completes the mask.
- **Back-to-back presses:** presses on different buttons at least 1 cycle apart are all honoured, in arrival order.
- **Reset mid-operation:** `rst` asserted during a strobe or a debounce count returns every output to its reset value immediately (asynchronously). No partial write is emitted after release.
- **Buttons held through reset:** a button held through `rst` deassertion produces a press only after a full debounce, counted from the release of reset.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4.
- **Reset:** after `rst`, outputs = 0 except `rotor_pos_out`=11.
  - 3 ok presses → strobes on rotor codes 00, 01, 10, each with `init_pos_out`=0.
  - `config_done`=1 after the third strobe.
- **Bounce:** `btn_up` toggling every 2 cycles for 20 cycles, then held high → exactly one increment, `edit_val`=1.
  - The increment lands DEBOUNCE_CYCLES+3 edges after the final rising edge.
- **Wrap:** from 0, down → 25; then up → 0.
  - 27 up presses from 0 → `edit_val`=1.
- **Shadow reload:**
  - up ×5 then ok → strobe r=0, data 5; `rotor_sel`=1, `edit_val`=0.
  - sel, sel → `rotor_sel`=0, `edit_val`=5.
  - up ×3, then sel without ok → rotor 0 shadow stays 5 and no strobe occurs.
- **Simultaneous presses:** `btn_ok` and `btn_up` rising in the same cycle → one commit of the unincremented value, no increment.
  - `btn_sel`+`btn_down` together → select only.
- **Reset mid-strobe:** assert `rst` in the `write_en` cycle → `write_en`=0, `rotor_pos_out`=11, `done_mask` cleared.
  - Afterwards, three fresh ok presses are required before `config_done`=1.
